// File: rtl/alu_issue_ctrl.sv
// Command FIFO and issue controller that feeds a combinational ALU from registers and returns results in order.
// Define ALU_ISSUE_OPCHECK_EN to reject opcode 3'b111 with rsp_err instead of issuing it.
module alu_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [2:0]               cmd_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_s0,
  output logic                     alu_s1,
  output logic                     alu_s2,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [2:0]               rsp_op,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } cmd_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            push, pop, load, capture, reject, rsp_clear, cnt_dec;
  logic            illegal_op;

  assign head      = mem[rd_ptr];
  assign cmd_ready = (level < LW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE) || (level != '0);

`ifdef ALU_ISSUE_OPCHECK_EN
  assign illegal_op = (head.op == 3'b111);
`else
  assign illegal_op = 1'b0;
`endif

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    reject     = 1'b0;
    rsp_clear  = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop = 1'b1;
          if (illegal_op) begin
            reject     = 1'b1;
            state_next = RESP;
          end else begin
            load       = 1'b1;
            state_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: FIFO storage is deliberately not reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s0     <= 1'b0;
      alu_s1     <= 1'b0;
      alu_s2     <= 1'b0;
      op_q       <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
    end else begin
      if (load) begin
        alu_a  <= head.a;
        alu_b  <= head.b;
        alu_s0 <= head.op[2];
        alu_s1 <= head.op[1];
        alu_s2 <= head.op[0];
        op_q   <= head.op;
        cnt    <= CW'(SETTLE_CYCLES - 1);
      end else if (cnt_dec) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_op     <= op_q;
        rsp_valid  <= 1'b1;
      end else if (reject) begin
        rsp_result <= '0;
        rsp_op     <= head.op;
        rsp_valid  <= 1'b1;
      end else if (rsp_clear) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_OPCHECK_EN
  always_ff @(posedge clk) begin
    if (rst)          rsp_err <= 1'b0;
    else if (capture) rsp_err <= 1'b0;
    else if (reject)  rsp_err <= 1'b1;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus a randomized run scored against a queue model.
// A stand-in combinational ALU drives alu_result from the DUT's registered ALU inputs.
module tb_alu_issue_ctrl;
  localparam int W = 32;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [W-1:0]     cmd_a = '0, cmd_b = '0;
  logic [2:0]       cmd_op = '0;
  logic [W-1:0]     alu_a, alu_b, alu_result;
  logic             alu_s0, alu_s1, alu_s2;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_result;
  logic [2:0]       rsp_op;
  logic             rsp_err;
  logic             busy;
  logic [$clog2(D):0] level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } cmd_t;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   op;
    logic         err;
  } rsp_t;

  cmd_t pend_q[$];
  rsp_t exp_q[$];

  alu_issue_ctrl #(.WIDTH(W), .DEPTH(D), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a | b);
      3'd6:    return a << b[4:0];
      default: return (a < b) ? W'(1) : W'(0);
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, {alu_s0, alu_s1, alu_s2});

  function automatic rsp_t model(cmd_t c);
    rsp_t r;
    r.op  = c.op;
    r.res = alu_f(c.a, c.b, c.op);
    r.err = 1'b0;
`ifdef ALU_ISSUE_OPCHECK_EN
    if (c.op == 3'b111) begin
      r.res = '0;
      r.err = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives pend_q into the DUT and scores every response against exp_q until both drain.
  task automatic run(input int budget, input int ready_pct);
    bit done = 1'b0;
    bit hold = 1'b0;
    logic [W-1:0] h_res = '0;
    logic [2:0]   h_op = '0;
    rsp_t e;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (hold) begin
        check("hold_valid", W'(rsp_valid), W'(1));
        check("hold_result", rsp_result, h_res);
        check("hold_op", W'(rsp_op), W'(h_op));
      end
      rsp_ready = ($urandom_range(99) < ready_pct);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", W'(rsp_valid), W'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_result", rsp_result, e.res);
          check("rsp_op", W'(rsp_op), W'(e.op));
          check("rsp_err", W'(rsp_err), W'(e.err));
        end
      end
      hold  = rsp_valid && !rsp_ready;
      h_res = rsp_result;
      h_op  = rsp_op;
      if (pend_q.size() > 0 && $urandom_range(3) != 0) begin
        cmd_valid = 1'b1;
        cmd_a     = pend_q[0].a;
        cmd_b     = pend_q[0].b;
        cmd_op    = pend_q[0].op;
        if (cmd_ready) begin
          exp_q.push_back(model(pend_q[0]));
          void'(pend_q.pop_front());
        end
      end else begin
        cmd_valid = 1'b0;
      end
      done = (pend_q.size() == 0) && (exp_q.size() == 0) && !busy && !cmd_valid;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("run_complete", W'(done), W'(1));
  endtask

  initial begin
    logic [W-1:0] a, b, pa, pb;
    logic [2:0]   ps;
    cmd_t         c;
    bit           seen;

    // Reset held for two cycles with a command offered.
    rst = 1'b1; cmd_valid = 1'b1; cmd_a = 32'hDEAD_BEEF; cmd_b = 32'h1234; cmd_op = 3'd2;
    tick();
    tick();
    check("rst_cmd_ready", W'(cmd_ready), W'(1));
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_level", W'(level), W'(0));
    check("rst_alu_a", alu_a, W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_rsp_result", rsp_result, W'(0));
    check("rst_rsp_op", W'(rsp_op), W'(0));
    check("rst_rsp_err", W'(rsp_err), W'(0));
    rst = 1'b0; cmd_valid = 1'b0;
    tick();
    check("rst_nothing_accepted", W'(level), W'(0));

    // Single op with C0..C4 timing.
    cmd_valid = 1'b1; cmd_a = 32'h5840; cmd_b = 32'h6230; cmd_op = 3'b000;
    check("single_c0_ready", W'(cmd_ready), W'(1));
    tick();
    cmd_valid = 1'b0;
    check("single_c1_level", W'(level), W'(1));
    check("single_c1_alu_a_old", alu_a, W'(0));
    check("single_c1_busy", W'(busy), W'(1));
    tick();
    check("single_c2_alu_a", alu_a, 32'h5840);
    check("single_c2_alu_b", alu_b, 32'h6230);
    check("single_c2_sel", W'({alu_s0, alu_s1, alu_s2}), W'(0));
    check("single_c2_rsp_valid", W'(rsp_valid), W'(0));
    tick();
    check("single_c3_rsp_valid", W'(rsp_valid), W'(1));
    check("single_c3_result", rsp_result, 32'h5840 + 32'h6230);
    check("single_c3_op", W'(rsp_op), W'(0));
    check("single_c3_err", W'(rsp_err), W'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("single_c4_rsp_valid", W'(rsp_valid), W'(0));
    check("single_c4_busy", W'(busy), W'(0));

    // Burst of ops 0..6 with rsp_ready low: five accepted, then FIFO full.
    a = $urandom; b = $urandom;
    for (int k = 0; k < 6; k++) begin
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = 3'(k);
      if (k < 5) begin
        check($sformatf("burst_ready_c%0d", k), W'(cmd_ready), W'(1));
        c = '{a: a, b: b, op: 3'(k)};
        exp_q.push_back(model(c));
      end else begin
        check("burst_ready_c5", W'(cmd_ready), W'(0));
        check("burst_level_c5", W'(level), W'(D));
      end
      tick();
    end
    check("burst_still_full", W'(cmd_ready), W'(0));
    pend_q.push_back('{a: a, b: b, op: 3'd5});
    pend_q.push_back('{a: a, b: b, op: 3'd6});
    run(200, 100);

    // Backpressure: response held for 10 cycles must not move.
    a = $urandom; b = $urandom;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = 3'd3;
    tick();
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = rsp_valid;
    end
    check("bp_rsp_arrived", W'(seen), W'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", W'(rsp_valid), W'(1));
      check("bp_result", rsp_result, a | b);
      check("bp_op", W'(rsp_op), W'(3));
      check("bp_alu_a", alu_a, a);
      check("bp_alu_b", alu_b, b);
      check("bp_sel", W'({alu_s0, alu_s1, alu_s2}), W'(3));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_released", W'(rsp_valid), W'(0));

    // Opcode 3'b111.
    pa = alu_a; pb = alu_b; ps = {alu_s0, alu_s1, alu_s2};
    a = $urandom; b = $urandom;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = 3'b111;
    tick();
    cmd_valid = 1'b0;
    tick();
`ifdef ALU_ISSUE_OPCHECK_EN
    check("ill_c2_valid", W'(rsp_valid), W'(1));
    check("ill_c2_err", W'(rsp_err), W'(1));
    check("ill_c2_result", rsp_result, W'(0));
    check("ill_c2_op", W'(rsp_op), W'(7));
    check("ill_alu_a_kept", alu_a, pa);
    check("ill_alu_b_kept", alu_b, pb);
    check("ill_sel_kept", W'({alu_s0, alu_s1, alu_s2}), W'(ps));
`else
    check("op7_sel", W'({alu_s0, alu_s1, alu_s2}), W'(7));
    check("op7_alu_a", alu_a, a);
    check("op7_c2_valid", W'(rsp_valid), W'(0));
    tick();
    check("op7_c3_valid", W'(rsp_valid), W'(1));
    check("op7_result", rsp_result, (a < b) ? W'(1) : W'(0));
    check("op7_err", W'(rsp_err), W'(0));
    check("op7_op", W'(rsp_op), W'(7));
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("op7_released", W'(rsp_valid), W'(0));

    // Reset while SETTLE is active with three commands still queued.
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 3'(k);
      check($sformatf("mid_fill_ready_%0d", k), W'(cmd_ready), W'(1));
      tick();
    end
    cmd_valid = 1'b0;
    check("mid_full_level", W'(level), W'(D));
    check("mid_first_rsp", W'(rsp_valid), W'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("mid_rsp_taken", W'(rsp_valid), W'(0));
    tick();
    check("mid_settle_level", W'(level), W'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_level", W'(level), W'(0));
    check("mid_rst_rsp_valid", W'(rsp_valid), W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_alu_a", alu_a, W'(0));
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    rsp_ready = 1'b0;
    check("mid_no_rsp_after_rst", W'(seen), W'(0));

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 60; i++) begin
      c.a  = $urandom;
      c.b  = $urandom;
      c.op = 3'($urandom_range(7));
      pend_q.push_back(c);
    end
    run(3000, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
